// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// definitions
//   Shared types and constants for the 3BC fetch sequencer.
//   - state_t        : fetch FSM state (IDLE / RUN / HALT)
//   - kBranchOffsets : 32-entry table of signed branch offsets, indexed by the
//                      instruction immediate when the offset comes from the LUT
// ----------------------------------------------------------------------------
package definitions;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int LUT_DEPTH = 32;
  localparam int LUT_OFF_W = 8;

  // Index 0 is a zero offset (self-loop). Short hops come first, and the
  // longest reaches of +127/-127 come after them.
  localparam logic signed [LUT_OFF_W-1:0] kBranchOffsets [LUT_DEPTH] = '{
    8'sd0,    8'sd1,    8'sd2,    8'sd6,
    -8'sd1,   -8'sd2,   -8'sd3,   -8'sd4,
    8'sd4,    8'sd8,    8'sd16,   8'sd32,
    8'sd64,   8'sd127,  -8'sd127, -8'sd8,
    -8'sd16,  -8'sd32,  -8'sd64,  8'sd3,
    8'sd5,    8'sd7,    8'sd9,    8'sd11,
    -8'sd5,   -8'sd7,   -8'sd9,   -8'sd11,
    8'sd12,   -8'sd12,  8'sd20,   -8'sd20
  };

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// ----------------------------------------------------------------------------
// branch_lut
//   Purely combinational lookup from the instruction immediate to a signed
//   branch offset, resized to OFF_W bits by sign extension or truncation.
//
//   Ports:
//     lut_idx : LUT_AW-bit index taken from the instruction immediate
//     offset  : OFF_W-bit signed offset from kBranchOffsets
// ----------------------------------------------------------------------------
module branch_lut
  import definitions::*;
#(
  parameter int OFF_W  = 8,
  parameter int LUT_AW = 5
) (
  input  logic        [LUT_AW-1:0] lut_idx,
  output logic signed [OFF_W-1:0]  offset
);

  // The table is a constant, so this is pure decode logic with no storage to
  // initialise or reset.
  always_comb begin
    offset = OFF_W'(kBranchOffsets[lut_idx]);
  end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   Program counter and fetch sequencer for the 3BC processor. It owns the
//   start/done handshake with the testbench, the PC register, the branch
//   target adder and a saturating count of the cycles spent in RUN.
//
//   Ports:
//     Clk        : clock. All state changes on the rising edge.
//     Reset      : synchronous active-low reset
//     Start      : 1 = hold in IDLE and load StartAddr. Falling edge begins RUN.
//     StartAddr  : program entry address, sampled while Start=1
//     Ack        : current instruction is halt
//     BranchEn   : current instruction is a conditional branch
//     Cond       : ALU branch condition for the current instruction
//     OffsetSrc  : 1 = RegOffset, 0 = LUT[LutIdx]
//     LutIdx     : LUT index from the instruction immediate
//     RegOffset  : signed offset from the register file
//     PC         : instruction-ROM address (registered)
//     Running    : FSM is in RUN
//     Done       : FSM is in HALT
//     CycleCount : RUN cycles so far, saturating at all-ones
// ----------------------------------------------------------------------------
module fetch_unit
  import definitions::*;
#(
  parameter int PC_W   = 10,
  parameter int OFF_W  = 8,
  parameter int LUT_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic        [PC_W-1:0]  StartAddr,
  input  logic                    Ack,
  input  logic                    BranchEn,
  input  logic                    Cond,
  input  logic                    OffsetSrc,
  input  logic        [LUT_AW-1:0] LutIdx,
  input  logic signed [OFF_W-1:0] RegOffset,
  output logic        [PC_W-1:0]  PC,
  output logic                    Running,
  output logic                    Done,
  output logic        [CNT_W-1:0] CycleCount
);

  state_t state;

  logic signed [OFF_W-1:0] lut_offset;
  logic signed [OFF_W-1:0] offset;
  logic        [PC_W-1:0]  offset_ext;
  logic        [PC_W-1:0]  target;
  logic        [PC_W-1:0]  pc_inc;

  branch_lut #(
    .OFF_W  (OFF_W),
    .LUT_AW (LUT_AW)
  ) u_branch_lut (
    .lut_idx (LutIdx),
    .offset  (lut_offset)
  );

  // NOTE: every variable in this block is assigned on every path. A path
  // that left one unassigned would make synthesis infer a latch.
  always_comb begin
    offset     = OffsetSrc ? RegOffset : lut_offset;
    // A size cast of a signed value sign-extends. The adder then wraps
    // modulo 2^PC_W, with no overflow detection.
    offset_ext = PC_W'(offset);
    target     = PC + offset_ext;
    pc_inc     = PC + PC_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values of all the others.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= IDLE;
      PC         <= '0;
      CycleCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            PC         <= StartAddr;
            CycleCount <= '0;
          end else begin
            // PC is left unchanged, so the first RUN cycle fetches the loaded
            // entry address, or 0 if Start was never raised.
            state <= RUN;
          end
        end

        RUN: begin
          // The Ack cycle counts too, so the total includes the halt.
          if (CycleCount != '1) begin
            CycleCount <= CycleCount + CNT_W'(1);
          end

          if (Start) begin
            state <= IDLE;
            PC    <= StartAddr;
          end else if (Ack) begin
            // PC holds so the halt instruction stays addressed. Any branch
            // on the halt instruction is ignored.
            state <= HALT;
          end else if (BranchEn && Cond) begin
            PC <= target;
          end else begin
            PC <= pc_inc;
          end
        end

        HALT: begin
          if (Start) begin
            state <= IDLE;
            PC    <= StartAddr;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign Running = (state == RUN);
  assign Done    = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. One task per scenario, called in sequence,
//   each with inline comparisons against hand-computed values. A second
//   instance with a 4-bit counter shares the same inputs and exercises
//   counter saturation.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

  logic              clk;
  logic              reset;
  logic              start;
  logic [9:0]        start_addr;
  logic              ack;
  logic              branch_en;
  logic              cond;
  logic              offset_src;
  logic [4:0]        lut_idx;
  logic signed [7:0] reg_offset;

  logic [9:0]  pc;
  logic        running;
  logic        done;
  logic [15:0] cycle_count;

  logic [9:0]  pc_s;
  logic        running_s;
  logic        done_s;
  logic [3:0]  cycle_count_s;

  int errors = 0;
  int checks = 0;

  fetch_unit dut (
    .Clk        (clk),
    .Reset      (reset),
    .Start      (start),
    .StartAddr  (start_addr),
    .Ack        (ack),
    .BranchEn   (branch_en),
    .Cond       (cond),
    .OffsetSrc  (offset_src),
    .LutIdx     (lut_idx),
    .RegOffset  (reg_offset),
    .PC         (pc),
    .Running    (running),
    .Done       (done),
    .CycleCount (cycle_count)
  );

  fetch_unit #(.CNT_W(4)) dut_small (
    .Clk        (clk),
    .Reset      (reset),
    .Start      (start),
    .StartAddr  (start_addr),
    .Ack        (ack),
    .BranchEn   (branch_en),
    .Cond       (cond),
    .OffsetSrc  (offset_src),
    .LutIdx     (lut_idx),
    .RegOffset  (reg_offset),
    .PC         (pc_s),
    .Running    (running_s),
    .Done       (done_s),
    .CycleCount (cycle_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge, so
  // inputs are driven and outputs sampled away from the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_ctrl();
    ack        = 1'b0;
    branch_en  = 1'b0;
    cond       = 1'b0;
    offset_src = 1'b0;
    lut_idx    = '0;
    reg_offset = '0;
  endtask

  // Load addr through IDLE (Start held two edges, so the counter is cleared
  // even when coming from HALT) and enter RUN. On return, the first RUN
  // cycle is fetching addr, and CycleCount is 0.
  task automatic goto_addr(input logic [9:0] addr);
    start      = 1'b1;
    start_addr = addr;
    tick(2);
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    start_addr = 10'h3AA;
    clear_ctrl();
    tick(2);
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 10'h000); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
    reset = 1'b1;
  endtask

  task automatic test_start_run();
    start = 1'b1;
    start_addr = 10'h040;
    tick();
    checks++; if (pc !== 10'h040) begin errors++; $display("FAIL start_load_pc got=%h exp=040", pc); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_idle_running got=%b exp=0", running); end
    start = 1'b0;
    tick();
    checks++; if (pc !== 10'h040) begin errors++; $display("FAIL run_first_pc got=%h exp=040", pc); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running got=%b exp=1", running); end
    tick();
    checks++; if (pc !== 10'h041) begin errors++; $display("FAIL run_pc1 got=%h exp=041", pc); end
    tick();
    checks++; if (pc !== 10'h042) begin errors++; $display("FAIL run_pc2 got=%h exp=042", pc); end
    checks++; if (cycle_count !== 16'd2) begin errors++; $display("FAIL run_count got=%0d exp=2", cycle_count); end
  endtask

  task automatic test_taken_branch();
    // Register offset -4 from 0x010.
    goto_addr(10'h010);
    branch_en = 1'b1; cond = 1'b1; offset_src = 1'b1; reg_offset = 8'hFC;
    tick();
    checks++; if (pc !== 10'h00C) begin errors++; $display("FAIL br_reg_neg got=%h exp=00C", pc); end
    clear_ctrl();

    // LUT entry 3 is +6.
    goto_addr(10'h010);
    branch_en = 1'b1; cond = 1'b1; offset_src = 1'b0; lut_idx = 5'd3;
    tick();
    checks++; if (pc !== 10'h016) begin errors++; $display("FAIL br_lut3 got=%h exp=016", pc); end
    clear_ctrl();

    // LUT entry 14 is -127: 0x010 - 127 wraps to 0x391.
    goto_addr(10'h010);
    branch_en = 1'b1; cond = 1'b1; offset_src = 1'b0; lut_idx = 5'd14;
    tick();
    checks++; if (pc !== 10'h391) begin errors++; $display("FAIL br_lut14_wrap got=%h exp=391", pc); end
    clear_ctrl();
  endtask

  task automatic test_not_taken_wrap();
    goto_addr(10'h020);
    branch_en = 1'b1; cond = 1'b0; offset_src = 1'b1; reg_offset = 8'sd40;
    tick();
    checks++; if (pc !== 10'h021) begin errors++; $display("FAIL nt_cond0 got=%h exp=021", pc); end
    branch_en = 1'b0; cond = 1'b1;
    tick();
    checks++; if (pc !== 10'h022) begin errors++; $display("FAIL nt_en0 got=%h exp=022", pc); end
    clear_ctrl();

    goto_addr(10'h3FF);
    tick();
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL inc_wrap got=%h exp=000", pc); end

    goto_addr(10'h3FE);
    branch_en = 1'b1; cond = 1'b1; offset_src = 1'b1; reg_offset = 8'sd5;
    tick();
    checks++; if (pc !== 10'h003) begin errors++; $display("FAIL br_wrap got=%h exp=003", pc); end
    clear_ctrl();

    // Zero offset (LUT entry 0) is a self-loop, while the counter keeps going.
    goto_addr(10'h050);
    branch_en = 1'b1; cond = 1'b1; offset_src = 1'b0; lut_idx = 5'd0;
    tick(2);
    checks++; if (pc !== 10'h050) begin errors++; $display("FAIL self_loop_pc got=%h exp=050", pc); end
    checks++; if (cycle_count !== 16'd2) begin errors++; $display("FAIL self_loop_count got=%0d exp=2", cycle_count); end
    clear_ctrl();
  endtask

  task automatic test_halt();
    int bad;
    // Start 11 before 0x025, so Ack is seen on the 12th RUN cycle.
    goto_addr(10'h01A);
    tick(11);
    checks++; if (pc !== 10'h025) begin errors++; $display("FAIL halt_pre_pc got=%h exp=025", pc); end
    ack = 1'b1; branch_en = 1'b1; cond = 1'b1; offset_src = 1'b1; reg_offset = 8'sd5;
    tick();
    checks++; if (pc !== 10'h025) begin errors++; $display("FAIL halt_pc got=%h exp=025", pc); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done got=%b exp=1", done); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL halt_running got=%b exp=0", running); end
    checks++; if (cycle_count !== 16'd12) begin errors++; $display("FAIL halt_count got=%0d exp=12", cycle_count); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (pc !== 10'h025 || done !== 1'b1 || running !== 1'b0 || cycle_count !== 16'd12) begin
        errors++;
        if (bad == 0)
          $display("FAIL halt_hold cyc=%0d pc=%h done=%b run=%b cnt=%0d exp pc=025 done=1 run=0 cnt=12",
                   i, pc, done, running, cycle_count);
        bad++;
      end
    end
  endtask

  task automatic test_restart_abort();
    clear_ctrl();
    start = 1'b1; start_addr = 10'h100;
    tick();
    checks++; if (pc !== 10'h100) begin errors++; $display("FAIL restart_pc got=%h exp=100", pc); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_done got=%b exp=0", done); end
    tick();
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL restart_count got=%0d exp=0", cycle_count); end
    start = 1'b0;
    tick();
    checks++; if (pc !== 10'h100 || running !== 1'b1) begin errors++; $display("FAIL restart_run pc=%h run=%b exp pc=100 run=1", pc, running); end
    tick();
    checks++; if (pc !== 10'h101) begin errors++; $display("FAIL restart_pc1 got=%h exp=101", pc); end
    checks++; if (cycle_count !== 16'd1) begin errors++; $display("FAIL restart_count1 got=%0d exp=1", cycle_count); end

    // Abort mid-RUN.
    start = 1'b1; start_addr = 10'h200;
    tick();
    checks++; if (running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_state run=%b done=%b exp run=0 done=0", running, done); end
    checks++; if (pc !== 10'h200) begin errors++; $display("FAIL abort_pc got=%h exp=200", pc); end
    start = 1'b0;
    tick(3);
    checks++; if (pc !== 10'h202) begin errors++; $display("FAIL abort_rerun_pc got=%h exp=202", pc); end

    // Reset takes priority over Start and Ack at the same edge.
    reset = 1'b0; ack = 1'b1; start = 1'b1; start_addr = 10'h155;
    tick();
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL rst_mid_pc got=%h exp=000", pc); end
    checks++; if (running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_state run=%b done=%b exp run=0 done=0", running, done); end
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL rst_mid_count got=%0d exp=0", cycle_count); end
    reset = 1'b1; ack = 1'b0; start = 1'b0;
    tick();
    checks++; if (pc !== 10'h000 || running !== 1'b1) begin errors++; $display("FAIL rst_run0 pc=%h run=%b exp pc=000 run=1", pc, running); end
    tick();
    checks++; if (pc !== 10'h001) begin errors++; $display("FAIL rst_run1 got=%h exp=001", pc); end
  endtask

  task automatic test_saturation();
    clear_ctrl();
    goto_addr(10'h000);
    tick(20);
    checks++; if (cycle_count_s !== 4'hF) begin errors++; $display("FAIL sat_small got=%h exp=F", cycle_count_s); end
    checks++; if (cycle_count !== 16'd20) begin errors++; $display("FAIL sat_wide got=%0d exp=20", cycle_count); end
    checks++; if (pc_s !== 10'd20) begin errors++; $display("FAIL sat_small_pc got=%h exp=014", pc_s); end
    tick(5);
    checks++; if (cycle_count_s !== 4'hF) begin errors++; $display("FAIL sat_hold got=%h exp=F", cycle_count_s); end
    checks++; if (cycle_count !== 16'd25) begin errors++; $display("FAIL sat_wide2 got=%0d exp=25", cycle_count); end
  endtask

  initial begin
    test_reset();
    test_start_run();
    test_taken_branch();
    test_not_taken_wrap();
    test_halt();
    test_restart_abort();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch sequencer for the 3BC processor. It consumes the per-instruction control outputs of the decoder (halt `Ack`, branch enable, offset source) and the ALU branch condition, and produces the instruction-ROM address each cycle. It also owns the start/done handshake with the testbench and a run-cycle counter. It sits between the decoder/ALU and the instruction ROM.

## Interface
- `PC_W`, default 10: PC width; instruction ROM depth is 2^PC_W.
- `OFF_W`, default 8: signed branch offset width.
- `LUT_AW`, default 5: offset-LUT index width (32 entries).
- `CNT_W`, default 16: cycle counter width.

Ports:
- `Clk` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: synchronous, active-low reset.
- `Start` input 1: level from the testbench; high means hold/load, and the falling edge begins execution.
- `StartAddr` input PC_W: program entry address, sampled while `Start`=1.
- `Ack` input 1: the current instruction is the halt instruction (all ones).
- `BranchEn` input 1: the current instruction is a conditional branch.
- `Cond` input 1: ALU branch condition for the current instruction.
- `OffsetSrc` input 1: 1 = offset from `RegOffset`; 0 = offset from the LUT.
- `LutIdx` input LUT_AW: LUT index taken from the instruction immediate.
- `RegOffset` input OFF_W: signed offset read from the register file.
- `PC` output PC_W: instruction-ROM address.
- `Running` output 1: the FSM is in RUN.
- `Done` output 1: the FSM is in HALT.
- `CycleCount` output CNT_W: number of cycles spent in RUN.

## Operation
- States are IDLE, RUN and HALT. Reset (`Reset`=0 at a clock edge) forces IDLE, `PC`=0, `CycleCount`=0, `Running`=0, `Done`=0.
- IDLE:
  - While `Start`=1: `PC` <= `StartAddr` and `CycleCount` <= 0.
  - When `Start`=0: go to RUN with `PC` unchanged.
  - A reset with `Start` never raised leaves `PC`=0, and RUN begins at 0.
- RUN, evaluated in priority order each cycle:
  - `Start`=1: abort. Go to IDLE and `PC` <= `StartAddr`.
  - `Ack`=1: go to HALT. `PC` holds, so the halt instruction stays addressed. `BranchEn` is ignored.
  - `BranchEn`&`Cond`: `PC` <= `PC` + sext(offset).
  - Otherwise: `PC` <= `PC` + 1.
- `CycleCount` increments on every RUN cycle, including the `Ack` cycle. It saturates at all-ones.
- Offset selection: `OffsetSrc`=1 uses `RegOffset`; otherwise the offset is LUT[`LutIdx`].
- The offset is sign-extended OFF_W→PC_W. The sum wraps modulo 2^PC_W, with no overflow detection.
- HALT: `PC` and `CycleCount` hold. `Start`=1 returns to IDLE and loads `StartAddr`. All other inputs are ignored.
- `Running` and `Done` decode directly from the registered state.

## Timing
- `PC` is registered. The instruction at `PC` is available combinationally in the same cycle, and the decoder and ALU inputs are valid in that same cycle.
- Branch or increment latency is one cycle, so the new `PC` appears after the edge. There is no delay slot and no bubble.
- `Start` falling at edge N means the first RUN cycle is N+1, executing `StartAddr`.
- `Ack` sampled at edge N means `Done`=1 and `Running`=0 from N+1. `CycleCount` then equals the number of instructions executed, including the halt.
- An offset of 0 is a self-loop: `PC` stays and the cycle counter keeps running.
- Reset mid-RUN takes priority over `Start` and `Ack` at that edge.
- Undefined inputs (`X`) are allowed on `BranchEn`, `Cond`, `OffsetSrc`, `LutIdx` and `RegOffset` outside RUN.

## Structure
- Shared package `definitions`: the state enum (IDLE, RUN, HALT), and the 32-entry signed offset LUT as a constant array `kBranchOffsets`.
- One sub-module, `branch_lut`: purely combinational, `LutIdx` → OFF_W signed offset from `kBranchOffsets`.
- The top level holds the FSM, PC register, target adder and counter.

## Test plan
- **Reset/start:** `Reset`=0 for 2 cycles → `PC`=0, `Done`=0, `CycleCount`=0. Then `Start`=1 with `StartAddr`=0x040, then `Start`=0 → `PC`=0x040, then 0x041, 0x042 on successive cycles, with `Running`=1.
- **Taken branches:**
  - `BranchEn`=1, `Cond`=1, `OffsetSrc`=1, `RegOffset`=8'hFC at `PC`=0x010 → next `PC`=0x00C.
  - The same with `OffsetSrc`=0 and `LutIdx`=3 → next `PC`=0x010+`kBranchOffsets[3]`.
- **Not taken and wrap:**
  - `Cond`=0 → `PC`+1.
  - `PC`=0x3FF with no branch → 0x000.
  - `PC`=0x3FE, offset +5 → 0x003.
- **Halt:** `Ack`=1 together with a taken branch at `PC`=0x025, after 12 RUN cycles → `PC` stays 0x025, `Done`=1, `Running`=0, `CycleCount`=12. These hold for 20 more cycles.
- **Restart and abort:**
  - From HALT, `Start`=1 with `StartAddr`=0x100, then `Start`=0 → `CycleCount`=0 and `PC` runs from 0x100.
  - `Start`=1 mid-RUN → IDLE on the next cycle.
  - `Reset`=0 together with `Ack`=1 → IDLE and `PC`=0.
- **Saturation:** with `CNT_W`=4, 20 RUN cycles → `CycleCount`=4'hF and it holds there.
